// File: rtl/pool_window_buffer.sv
// rtl/pool_window_buffer.sv - ping-pong row-pair buffer feeding the 2x2 max-pool stage
module pool_window_buffer #(
  parameter int DATA_W = 8,
  parameter int CH     = 6,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CH*DATA_W-1:0]     in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [CH*4*DATA_W-1:0]   out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last_col,
  output logic                     out_frame_end
);

  localparam int PX_W  = CH * DATA_W;
  localparam int WIN_W = 4 * DATA_W;
  localparam int CW    = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int PW    = (IMG_H > 2) ? $clog2(IMG_H / 2) : 1;
  localparam logic [CW-1:0] WR_LAST   = CW'(IMG_W - 1);
  localparam logic [CW-1:0] RD_LAST   = CW'(IMG_W - 2);
  localparam logic [PW-1:0] PAIR_LAST = PW'(IMG_H / 2 - 1);

  // mem[bank][row][col]; storage needs no reset because out_data is gated by out_valid
  logic [PX_W-1:0] mem [2][2][IMG_W];

  logic [1:0]    full, full_nxt;
  logic          wr_bank, wr_bank_nxt, wr_row, wr_row_nxt;
  logic [CW-1:0] wr_col, wr_col_nxt;
  logic          rd_bank, rd_bank_nxt;
  logic [CW-1:0] rd_col, rd_col_nxt, rd_col_p1;
  logic [PW-1:0] rd_pair, rd_pair_nxt;
  logic          in_ready_nxt;
  logic          accept, rd_xfer;
  logic [PX_W-1:0]        row0_a, row0_b, row1_a, row1_b;
  logic [CH*WIN_W-1:0]    win;

  assign accept    = in_valid && in_ready;
  assign rd_xfer   = out_valid && out_ready;
  assign rd_col_p1 = rd_col + 1'b1;

  assign out_valid     = full[rd_bank];
  assign out_last_col  = out_valid && (rd_col == RD_LAST);
  assign out_frame_end = out_last_col && (rd_pair == PAIR_LAST);

  assign row0_a = mem[rd_bank][1'b0][rd_col];
  assign row0_b = mem[rd_bank][1'b0][rd_col_p1];
  assign row1_a = mem[rd_bank][1'b1][rd_col];
  assign row1_b = mem[rd_bank][1'b1][rd_col_p1];

  always_comb begin
    win = '0;
    for (int c = 0; c < CH; c++) begin
      win[c*WIN_W +: WIN_W] = {row0_a[c*DATA_W +: DATA_W], row0_b[c*DATA_W +: DATA_W],
                               row1_a[c*DATA_W +: DATA_W], row1_b[c*DATA_W +: DATA_W]};
    end
  end

  assign out_data = out_valid ? win : '0;

  always_comb begin
    full_nxt    = full;
    wr_bank_nxt = wr_bank;
    wr_row_nxt  = wr_row;
    wr_col_nxt  = wr_col;
    rd_bank_nxt = rd_bank;
    rd_col_nxt  = rd_col;
    rd_pair_nxt = rd_pair;

    if (accept) begin
      if (wr_col == WR_LAST) begin
        wr_col_nxt = '0;
        wr_row_nxt = ~wr_row;
        if (wr_row) begin
          full_nxt[wr_bank] = 1'b1;
          wr_bank_nxt       = ~wr_bank;
        end
      end else begin
        wr_col_nxt = wr_col + 1'b1;
      end
    end

    // The write side only ever fills a non-full bank, so this never collides with the set above
    if (rd_xfer) begin
      if (out_last_col) begin
        full_nxt[rd_bank] = 1'b0;
        rd_bank_nxt       = ~rd_bank;
        rd_col_nxt        = '0;
        rd_pair_nxt       = (rd_pair == PAIR_LAST) ? '0 : rd_pair + 1'b1;
      end else begin
        rd_col_nxt = rd_col + CW'(2);
      end
    end

    in_ready_nxt = !full_nxt[wr_bank_nxt];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full     <= '0;
      wr_bank  <= 1'b0;
      wr_row   <= 1'b0;
      wr_col   <= '0;
      rd_bank  <= 1'b0;
      rd_col   <= '0;
      rd_pair  <= '0;
      in_ready <= 1'b0;
    end else begin
      full     <= full_nxt;
      wr_bank  <= wr_bank_nxt;
      wr_row   <= wr_row_nxt;
      wr_col   <= wr_col_nxt;
      rd_bank  <= rd_bank_nxt;
      rd_col   <= rd_col_nxt;
      rd_pair  <= rd_pair_nxt;
      in_ready <= in_ready_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_bank][wr_row][wr_col] <= in_data;
    end
  end

endmodule

// File: tb/tb_pool_window_buffer.sv
// tb/tb_pool_window_buffer.sv - scoreboard bench for pool_window_buffer (default and small builds)
module tb_pool_window_buffer;
  localparam int DW  = 8;
  localparam int CH  = 6;
  localparam int W   = 28;
  localparam int H   = 28;
  localparam int PCH = 16;
  localparam int PWD = 10;
  localparam int PHT = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [CH*DW-1:0]    in_data;
  logic                in_valid, in_ready;
  logic [CH*4*DW-1:0]  out_data;
  logic                out_valid, out_ready, out_last_col, out_frame_end;

  logic [PCH*DW-1:0]   p_in_data;
  logic                p_in_valid, p_in_ready;
  logic [PCH*4*DW-1:0] p_out_data;
  logic                p_out_valid, p_out_ready, p_out_last_col, p_out_frame_end;

  pool_window_buffer #(.DATA_W(DW), .CH(CH), .IMG_W(W), .IMG_H(H)) u_dut (
    .clk(clk), .reset(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last_col(out_last_col), .out_frame_end(out_frame_end));

  pool_window_buffer #(.DATA_W(DW), .CH(PCH), .IMG_W(PWD), .IMG_H(PHT)) u_dut_p (
    .clk(clk), .reset(rst), .in_data(p_in_data), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .out_data(p_out_data), .out_valid(p_out_valid), .out_ready(p_out_ready),
    .out_last_col(p_out_last_col), .out_frame_end(p_out_frame_end));

  typedef struct { logic [CH*4*DW-1:0] d; logic lc; logic fe; } exp_t;
  typedef struct { logic [PCH*4*DW-1:0] d; logic lc; logic fe; } pexp_t;

  exp_t  exp_q[$];
  pexp_t pexp_q[$];
  logic [PCH*DW-1:0] p_pix [PWD*PHT];

  int n_checks = 0;
  int n_fail = 0;
  int mon_lc, mon_fe, mon_fe_idx, ready_drops;
  logic [CH*4*DW-1:0] first_win;

  function automatic logic [DW-1:0] pix(int r, int c, int ch);
    return DW'(((r * W + c) & 255) ^ ch);
  endfunction

  function automatic logic [CH*DW-1:0] vec(int k);
    logic [CH*DW-1:0] v;
    for (int ch = 0; ch < CH; ch++) v[ch*DW +: DW] = pix(k / W, k % W, ch);
    return v;
  endfunction

  function automatic logic [CH*4*DW-1:0] win(int p, int j);
    logic [CH*4*DW-1:0] w;
    for (int ch = 0; ch < CH; ch++)
      w[ch*4*DW +: 4*DW] = {pix(2*p, 2*j, ch), pix(2*p, 2*j+1, ch), pix(2*p+1, 2*j, ch), pix(2*p+1, 2*j+1, ch)};
    return w;
  endfunction

  function automatic logic [PCH*4*DW-1:0] pwin(int p, int j);
    logic [PCH*4*DW-1:0] w;
    for (int ch = 0; ch < PCH; ch++)
      w[ch*4*DW +: 4*DW] = {p_pix[(2*p)*PWD + 2*j][ch*DW +: DW], p_pix[(2*p)*PWD + 2*j + 1][ch*DW +: DW],
                            p_pix[(2*p+1)*PWD + 2*j][ch*DW +: DW], p_pix[(2*p+1)*PWD + 2*j + 1][ch*DW +: DW]};
    return w;
  endfunction

  task automatic push_pair(input int p);
    exp_t e;
    for (int j = 0; j < W/2; j++) begin
      e.d = win(p, j); e.lc = (j == W/2 - 1); e.fe = e.lc && (p == H/2 - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_range(input int from, input int to, input int bubble_at);
    int cyc;
    for (int k = from; k < to; k++) begin
      if (k == bubble_at) begin
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = vec(k);
      cyc = 0;
      while (!in_ready && cyc < 2000) begin @(negedge clk); cyc++; end
      if (!in_ready) begin
        n_checks++; n_fail++;
        $display("FAIL drive_timeout: pixel %0d not accepted, in_ready=%b required 1", k, in_ready);
        in_valid = 1'b0;
        return;
      end
      if ((k % W) == W-1 && ((k / W) % 2) == 1) push_pair((k / W) / 2);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic monitor(input int n, input bit chk_ready, input string name);
    int got = 0;
    int cyc = 0;
    exp_t e;
    mon_lc = 0; mon_fe = 0; mon_fe_idx = -1; ready_drops = 0;
    out_ready = 1'b1;
    while (got < n && cyc < 5000) begin
      if (chk_ready && !in_ready) ready_drops++;
      if (out_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s_extra: window %0d got %h, required no window", name, got, out_data);
        end else begin
          e = exp_q.pop_front();
          if (got == 0) first_win = out_data;
          if (out_data !== e.d) begin n_fail++; $display("FAIL %s_data: window %0d got %h required %h", name, got, out_data, e.d); end
          n_checks++;
          if (out_last_col !== e.lc) begin n_fail++; $display("FAIL %s_last_col: window %0d got %b required %b", name, got, out_last_col, e.lc); end
          n_checks++;
          if (out_frame_end !== e.fe) begin n_fail++; $display("FAIL %s_frame_end: window %0d got %b required %b", name, got, out_frame_end, e.fe); end
        end
        if (out_last_col) mon_lc++;
        if (out_frame_end) begin mon_fe++; mon_fe_idx = got + 1; end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    if (got < n) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: got %0d windows, required %0d", name, got, n);
    end
  endtask

  task automatic run_frame(input int bubble_at, input string name);
    fork
      drive_range(0, W*H, bubble_at);
      monitor(W*H/4, 1'b1, name);
    join
    n_checks++; if (first_win[4*DW-1:0] !== 32'h00011C1D) begin n_fail++; $display("FAIL %s_first_ch0: got %h required 00011c1d", name, first_win[4*DW-1:0]); end
    n_checks++; if (mon_lc !== 14) begin n_fail++; $display("FAIL %s_last_col_count: got %0d required 14", name, mon_lc); end
    n_checks++; if (mon_fe !== 1 || mon_fe_idx !== 196) begin n_fail++; $display("FAIL %s_frame_end_pos: got count %0d at %0d required 1 at 196", name, mon_fe, mon_fe_idx); end
    n_checks++; if (ready_drops !== 0) begin n_fail++; $display("FAIL %s_in_ready_drop: got %0d low cycles required 0", name, ready_drops); end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL %s_leftover: got %0d windows queued required 0", name, exp_q.size()); end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    p_in_valid = 1'b0; p_in_data = '0; p_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL rst_out_data: got %h required 0", out_data); end
    n_checks++; if (out_last_col !== 1'b0 || out_frame_end !== 1'b0) begin n_fail++; $display("FAIL rst_flags: got %b%b required 00", out_last_col, out_frame_end); end
    n_checks++; if (in_ready !== 1'b0 || p_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b%b required 00", in_ready, p_in_ready); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1 || p_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_in_ready: got %b%b required 11", in_ready, p_in_ready); end
    n_checks++; if (out_valid !== 1'b0 || p_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_release_out_valid: got %b%b required 00", out_valid, p_out_valid); end
  endtask

  task automatic test_frame;
    run_frame(-1, "frame");
  endtask

  task automatic test_backpressure;
    logic [CH*4*DW-1:0] hold;
    exp_t e;
    out_ready = 1'b0;
    drive_range(0, 2*W, -1);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first_valid: got %b required 1", out_valid); end
    hold = out_data;
    drive_range(2*W, 4*W, -1);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_fall: got %b required 0", in_ready); end
    n_checks++; if (out_data !== hold || out_data !== win(0, 0)) begin n_fail++; $display("FAIL bp_hold: got %h required %h", out_data, win(0, 0)); end
    for (int i = 0; i < W/2; i++) begin
      out_ready = 1'b1;
      e = exp_q.pop_front();
      n_checks++; if (out_valid !== 1'b1 || out_data !== e.d) begin n_fail++; $display("FAIL bp_drain %0d: got v=%b %h required v=1 %h", i, out_valid, out_data, e.d); end
      if (i == W/2 - 1) begin
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_early: got %b required 0", in_ready); end
      end
      @(negedge clk);
    end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_rise: got %b required 1", in_ready); end
    fork
      drive_range(4*W, W*H, -1);
      monitor(W*H/4 - W/2, 1'b0, "bp_rest");
    join
  endtask

  task automatic test_back_to_back;
    exp_t e;
    out_ready = 1'b0;
    drive_range(0, 4*W, -1);
    for (int i = 0; i < W; i++) begin
      out_ready = 1'b1;
      e = exp_q.pop_front();
      n_checks++; if (out_valid !== 1'b1 || out_data !== e.d) begin n_fail++; $display("FAIL b2b_window %0d: got v=%b %h required v=1 %h", i, out_valid, out_data, e.d); end
      @(negedge clk);
    end
    fork
      drive_range(4*W, W*H, -1);
      monitor(W*H/4 - W, 1'b0, "b2b_rest");
    join
  endtask

  task automatic test_bubbles;
    run_frame(W + 12, "bubble");
  endtask

  task automatic test_reset_mid;
    fork
      drive_range(0, 2*W + 4, -1);
      monitor(3, 1'b0, "mid_pre");
    join
    #2 rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_data !== '0) begin n_fail++; $display("FAIL mid_async_out: got v=%b %h required v=0 0", out_valid, out_data); end
    n_checks++; if (in_ready !== 1'b0 || out_last_col !== 1'b0 || out_frame_end !== 1'b0) begin n_fail++; $display("FAIL mid_async_flags: got %b%b%b required 000", in_ready, out_last_col, out_frame_end); end
    @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_held: got %b%b required 00", out_valid, in_ready); end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    run_frame(-1, "after_reset");
  endtask

  task automatic test_param;
    int dcyc, mcyc, got, idx, fe_cnt;
    bit acc;
    logic [PCH*DW-1:0] d;
    pexp_t e;
    got = 0; fe_cnt = 0;
    fork
      begin
        for (int k = 0; k < 2*PWD*PHT; k++) begin
          idx = k % (PWD*PHT);
          d = {$urandom(), $urandom(), $urandom(), $urandom()};
          p_in_data = d; dcyc = 0; acc = 1'b0;
          while (!acc && dcyc < 3000) begin
            p_in_valid = ($urandom_range(0, 3) != 0);
            if (p_in_valid && p_in_ready) acc = 1'b1;
            else begin @(negedge clk); dcyc++; end
          end
          if (!acc) begin
            n_checks++; n_fail++;
            $display("FAIL param_drive_timeout: pixel %0d not accepted, required accept", k);
            break;
          end
          p_pix[idx] = d;
          if ((idx % PWD) == PWD-1 && ((idx / PWD) % 2) == 1) begin
            for (int j = 0; j < PWD/2; j++) begin
              e.d = pwin((idx / PWD) / 2, j); e.lc = (j == PWD/2 - 1); e.fe = e.lc && ((idx / PWD) / 2 == PHT/2 - 1);
              pexp_q.push_back(e);
            end
          end
          @(negedge clk);
        end
        p_in_valid = 1'b0;
      end
      begin
        mcyc = 0;
        while (got < 2*PWD*PHT/4 && mcyc < 6000) begin
          p_out_ready = ($urandom_range(0, 1) != 0);
          if (p_out_valid && p_out_ready) begin
            n_checks++;
            if (pexp_q.size() == 0) begin
              n_fail++; $display("FAIL param_extra: window %0d got %h required no window", got, p_out_data);
            end else begin
              e = pexp_q.pop_front();
              if (p_out_data !== e.d) begin n_fail++; $display("FAIL param_data: window %0d got %h required %h", got, p_out_data, e.d); end
              n_checks++;
              if (p_out_last_col !== e.lc || p_out_frame_end !== e.fe) begin n_fail++; $display("FAIL param_flags: window %0d got %b%b required %b%b", got, p_out_last_col, p_out_frame_end, e.lc, e.fe); end
            end
            if (p_out_frame_end) fe_cnt++;
            got++;
          end
          @(negedge clk);
          mcyc++;
        end
        p_out_ready = 1'b0;
      end
    join
    n_checks++; if (got !== 2*PWD*PHT/4) begin n_fail++; $display("FAIL param_count: got %0d windows required %0d", got, 2*PWD*PHT/4); end
    n_checks++; if (fe_cnt !== 2) begin n_fail++; $display("FAIL param_frame_end_count: got %0d required 2", fe_cnt); end
    n_checks++; if (pexp_q.size() !== 0) begin n_fail++; $display("FAIL param_leftover: got %0d queued required 0", pexp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_back_to_back();
    test_bubbles();
    test_reset_mid();
    test_param();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
